sobel_data_buffer_3x3: RTL and testbench
========================================

# sobel_data_buffer_3x3

Streaming 3x3 window generator in front of the Sobel gradient stage. It accepts one 8-bit pixel per enabled cycle in raster order (row-major, left to right) for a ROWS x COLS frame. It presents the nine pixels of the current 3x3 neighbourhood on d0_o..d8_o, and flags fully-inside-image windows with done_o. Row history lives in two internal line buffers.

## Interface
- DEPTH, 3: window height and width; only 3 is supported.
- ROWS, 240: frame height in pixels (≥3).
- COLS, 320: frame width in pixels (≥3).
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- we_i  in  1  pixel-valid strobe; data_i is accepted on every rising edge where we_i=1.
- data_i  in  8  input pixel.
- d0_o, d1_o, d2_o  out  8 each  top window row, oldest line, left to right: (r-2,c-2), (r-2,c-1), (r-2,c).
- d3_o, d4_o, d5_o  out  8 each  middle row: (r-1,c-2), (r-1,c-1), (r-1,c); d4_o is the window centre.
- d6_o, d7_o, d8_o  out  8 each  bottom row: (r,c-2), (r,c-1), (r,c), where (r,c) is the most recently accepted pixel.
- done_o  out  1  window valid: high for exactly the cycle following acceptance of a pixel with r≥2 and c≥2 (zero-based).

## Operation
- Column counter 0..COLS-1 and row counter 0..ROWS-1 advance only on accepted pixels.
  - Column wraps to 0 and increments the row.
  - After pixel (ROWS-1, COLS-1) both counters return to 0, and the next pixel starts a new frame.
- Line buffer A delays accepted pixels by exactly COLS accepted pixels and yields (r-1,c). Line buffer B delays A's output by COLS more and yields (r-2,c).
  - Both buffers shift only when we_i=1.
- Window: three 3-stage shift registers (top/middle/bottom), each fed by B output, A output and data_i respectively. They shift left-to-right on every accepted pixel.
- done_o = registered (we_i && row≥2 && col≥2) evaluated for the pixel being accepted.
  - Edge windows (r<2 or c<2), including the first two windows of every row, which contain pixels from the previous row's right edge, give done_o=0.
  - d*_o still update for these windows, but their contents are don't-care.
- we_i=0: no counter, buffer or window change. d*_o hold their values; done_o=0.
- Valid windows per frame = (ROWS-2)*(COLS-2).

## Timing
- Latency: a pixel accepted at edge k appears on d8_o, with done_o if applicable, after edge k. This is 1 cycle; all outputs are registered.
- Throughput: one pixel per cycle; no back-pressure.
- Reset (asynchronous, any time including mid-frame):
  - counters, window registers, d0_o..d8_o and done_o go to 0 immediately;
  - line-buffer RAM contents need not be cleared, because validity is gated by the row counter;
  - the first pixel after release is treated as (0,0).
- Gaps in we_i mid-row or mid-frame are transparent: the result is identical to a gap-free stream.

## Structure
- Shared package: PIX_W=8 constant; a helper for counter widths via $clog2(ROWS), $clog2(COLS).
- Sub-module line_buffer (parameters WIDTH, LEN; ports clk, rst, en, d, q). It is a LEN-deep enable-gated delay line (shift registers or circular RAM with a pointer) and is instantiated twice.
- Top level holds the counters, the 3x3 register array and done_o logic.

## Test plan
Unless noted, scenarios use ROWS=5, COLS=6 and feed values 1..30 continuously.
- Continuous feed of 1..30 with we_i=1 → exactly 12 done_o pulses. The first pulse comes the cycle after 15 is accepted, with d0..d8=1,2,3,7,8,9,13,14,15.
- Same stream, check at 16 → 2,3,4,8,9,10,14,15,16 with done_o=1. At 19 and 20 → done_o=0. At 21 → 7,8,9,13,14,15,19,20,21 with done_o=1.
- Last pixel 30 → 16,17,18,22,23,24,28,29,30 with done_o=1. The cycle after we_i drops → done_o=0, outputs hold.
- Random we_i gaps (about 30% idle) inserted in the 1..30 stream → identical sequence of 12 valid windows, with done_o never high on idle-following cycles.
- Assert rst=0 after pixel 17 → all outputs 0 at once. Re-feed 1..30 → the same 12 windows as the clean run.
- Two back-to-back frames (1..30, then 101..130) → second frame's first valid window is 101,102,103,107,108,109,113,114,115, with 24 pulses total.

Source files
------------

// File: rtl/sobel_data_buffer_3x3_pkg.sv
// Shared constants and sizing helper for the 3x3 Sobel window generator.
package sobel_data_buffer_3x3_pkg;

  localparam int PIX_W = 8;

  // Width of a counter or pointer covering 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_data_buffer_3x3_line_buffer.sv
// Enable-gated LEN-deep delay line built as a circular RAM with a single pointer.
module line_buffer
  import sobel_data_buffer_3x3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 320
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int PTR_W = cnt_w(LEN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LEN - 1);

  logic [WIDTH-1:0] mem [LEN];
  logic [PTR_W-1:0] ptr;

  // The slot about to be overwritten holds the sample written LEN enables ago,
  // so reading before the write yields exactly a LEN-sample delay.
  assign q = mem[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= d;
    end
  end

endmodule

// File: rtl/sobel_data_buffer_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 register window.
module sobel_data_buffer_3x3
  import sobel_data_buffer_3x3_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int ROWS  = 240,
  parameter int COLS  = 320
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [PIX_W-1:0] data_i,
  output logic [PIX_W-1:0] d0_o,
  output logic [PIX_W-1:0] d1_o,
  output logic [PIX_W-1:0] d2_o,
  output logic [PIX_W-1:0] d3_o,
  output logic [PIX_W-1:0] d4_o,
  output logic [PIX_W-1:0] d5_o,
  output logic [PIX_W-1:0] d6_o,
  output logic [PIX_W-1:0] d7_o,
  output logic [PIX_W-1:0] d8_o,
  output logic             done_o
);

  localparam int ROW_W = cnt_w(ROWS);
  localparam int COL_W = cnt_w(COLS);
  localparam int WIN   = DEPTH * DEPTH;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(DEPTH - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(DEPTH - 1);

  logic [ROW_W-1:0] row_p0;
  logic [COL_W-1:0] col_p0;
  logic [PIX_W-1:0] line_a;
  logic [PIX_W-1:0] line_b;
  logic [PIX_W-1:0] feed [DEPTH];
  logic [PIX_W-1:0] win_p1 [WIN];
  logic             vld_p1;

  line_buffer #(.WIDTH(PIX_W), .LEN(COLS)) u_line_a (
    .clk (clk),
    .rst (rst),
    .en  (we_i),
    .d   (data_i),
    .q   (line_a)
  );

  line_buffer #(.WIDTH(PIX_W), .LEN(COLS)) u_line_b (
    .clk (clk),
    .rst (rst),
    .en  (we_i),
    .d   (line_a),
    .q   (line_b)
  );

  // Column feeding each window row: oldest line on top, live pixel at the bottom.
  always_comb begin
    feed[0] = line_b;
    feed[1] = line_a;
    feed[2] = data_i;
  end

  // ---- stage p0: raster position of the pixel being accepted ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (we_i) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: window registers and validity flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) begin
        win_p1[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH - 1; j++) begin
          win_p1[i*DEPTH + j] <= win_p1[i*DEPTH + j + 1];
        end
        win_p1[i*DEPTH + DEPTH - 1] <= feed[i];
      end
    end
  end

  // Windows touching the top two rows or the left two columns are partial.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= we_i && (row_p0 >= ROW_MIN) && (col_p0 >= COL_MIN);
    end
  end

  assign d0_o   = win_p1[0];
  assign d1_o   = win_p1[1];
  assign d2_o   = win_p1[2];
  assign d3_o   = win_p1[3];
  assign d4_o   = win_p1[4];
  assign d5_o   = win_p1[5];
  assign d6_o   = win_p1[6];
  assign d7_o   = win_p1[7];
  assign d8_o   = win_p1[8];
  assign done_o = vld_p1;

endmodule

// File: tb/tb_sobel_data_buffer_3x3.sv
// Bench for sobel_data_buffer_3x3 on a 5x6 frame: scoreboard model plus fixed window vectors.
module tb_sobel_data_buffer_3x3;

  localparam int ROWS = 5;
  localparam int COLS = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic       done_o;

  always #5 clk = ~clk;

  sobel_data_buffer_3x3 #(.DEPTH(3), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .data_i (data_i),
    .d0_o   (d0_o),
    .d1_o   (d1_o),
    .d2_o   (d2_o),
    .d3_o   (d3_o),
    .d4_o   (d4_o),
    .d5_o   (d5_o),
    .d6_o   (d6_o),
    .d7_o   (d7_o),
    .d8_o   (d8_o),
    .done_o (done_o)
  );

  typedef struct packed {
    logic        chk_d;
    logic        done;
    logic [71:0] win;
  } exp_t;

  typedef struct {
    logic [7:0]  pix;
    logic        done;
    logic [71:0] win;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int mr = 0;
  int mc = 0;
  logic [7:0]  img [ROWS][COLS];
  logic [71:0] last_win = '0;
  logic        last_valid = 1'b0;

  function automatic logic [71:0] w9(input int a, input int b, input int c,
                                     input int d, input int e, input int f,
                                     input int g, input int h, input int i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  function automatic logic [71:0] dut_win();
    return {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle (accepted pixel or idle), then compare against the scoreboard.
  task automatic step(input logic we, input logic [7:0] pix);
    exp_t e;
    exp_t got;
    we_i   = we;
    data_i = pix;
    if (we) begin
      img[mr][mc] = pix;
      e.done  = (mr >= 2) && (mc >= 2);
      e.chk_d = e.done;
      e.win   = '0;
      if (e.done)
        e.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                 img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                 img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
      last_valid = e.done;
      last_win   = e.win;
      if (mc == COLS - 1) begin
        mc = 0;
        mr = (mr == ROWS - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end else begin
      e.done  = 1'b0;
      e.chk_d = last_valid;
      e.win   = last_win;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    if (done_o === 1'b1) pulses++;
    check(we ? "done" : "idle_done", {71'd0, done_o}, {71'd0, got.done});
    if (got.chk_d) check(we ? "window" : "idle_hold", dut_win(), got.win);
    if (we) begin
      for (int k = 0; k < 7; k++) begin
        if (vecs[k].pix == pix) begin
          check($sformatf("vec%0d_done", vecs[k].pix), {71'd0, done_o}, {71'd0, vecs[k].done});
          if (vecs[k].done) check($sformatf("vec%0d_win", vecs[k].pix), dut_win(), vecs[k].win);
        end
      end
    end
    we_i = 1'b0;
  endtask

  task automatic feed_frame(input int base, input int idle_pct);
    for (int p = 1; p <= ROWS * COLS; p++) begin
      while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) step(1'b0, 8'd0);
      step(1'b1, 8'(base + p));
    end
  endtask

  initial begin
    vecs[0] = '{8'd15,  1'b1, w9(1, 2, 3, 7, 8, 9, 13, 14, 15)};
    vecs[1] = '{8'd16,  1'b1, w9(2, 3, 4, 8, 9, 10, 14, 15, 16)};
    vecs[2] = '{8'd19,  1'b0, '0};
    vecs[3] = '{8'd20,  1'b0, '0};
    vecs[4] = '{8'd21,  1'b1, w9(7, 8, 9, 13, 14, 15, 19, 20, 21)};
    vecs[5] = '{8'd30,  1'b1, w9(16, 17, 18, 22, 23, 24, 28, 29, 30)};
    vecs[6] = '{8'd115, 1'b1, w9(101, 102, 103, 107, 108, 109, 113, 114, 115)};

    // Reset state
    #12;
    check("reset_done", {71'd0, done_o}, 72'd0);
    check("reset_win", dut_win(), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame, then an idle cycle that must hold the last window
    pulses = 0;
    feed_frame(0, 0);
    check("pulses_clean", 72'(pulses), 72'd12);
    step(1'b0, 8'd0);
    check("hold_after_30", dut_win(), w9(16, 17, 18, 22, 23, 24, 28, 29, 30));

    // Same frame with random idle gaps
    pulses = 0;
    feed_frame(0, 30);
    check("pulses_gaps", 72'(pulses), 72'd12);

    // Asynchronous reset mid-frame after pixel 17
    for (int p = 1; p <= 17; p++) step(1'b1, 8'(p));
    rst = 1'b0;
    #1;
    check("midreset_done", {71'd0, done_o}, 72'd0);
    check("midreset_win", dut_win(), 72'd0);
    mr = 0;
    mc = 0;
    last_valid = 1'b0;
    last_win = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    feed_frame(0, 0);
    check("pulses_after_reset", 72'(pulses), 72'd12);

    // Two back-to-back frames
    pulses = 0;
    feed_frame(0, 0);
    feed_frame(100, 0);
    check("pulses_two_frames", 72'(pulses), 72'd24);
    step(1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
